// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N:1 stream multiplexer with a registered output stage.
// Internal arbitration is either round-robin (RR=1) or fixed priority
// (RR=0, where the lowest index wins). Once the first beat of a multi-beat
// packet (in_last=0) is accepted, the block locks onto that channel and
// serves only it until the beat carrying in_last=1 has been taken.
//
// Ports:
//   Clk, Reset_n          clock and asynchronous active-low reset
//   in_data[N*WIDTH]      channel i is at bits [i*WIDTH +: WIDTH]
//   in_valid/in_last[N]   per-channel handshake and end-of-packet flag
//   in_ready[N]           one-hot (or zero) acceptance, combinational
//   out_data/out_last     registered beat
//   out_valid, out_ready  output handshake
//   out_sel[SELW]         channel that produced the current output beat
//   busy                  a packet is locked, or the output register is full

// Per-channel slice: acceptance for this channel and its contribution to the
// AND-OR data mux. The arbiter guarantees that at most one grant is set.
module stream_mux_rr_lane #(
  parameter int WIDTH = 16
) (
  input  logic             grant,
  input  logic             load_en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             xfer,
  output logic [WIDTH-1:0] sel_data,
  output logic             sel_last
);
  assign in_ready = load_en & grant;
  assign xfer     = in_ready & in_valid;
  assign sel_data = grant ? in_data : '0;
  assign sel_last = grant & in_last;
endmodule

module stream_mux_rr #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter bit RR    = 1'b1,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic               out_last,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready,
  output logic               busy
);
  typedef enum logic {IDLE, LOCKED} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  state_t                    state, state_nxt;
  logic [SELW-1:0]           rr_ptr, lock_ch, gnt_idx;
  logic                      gnt_any, load_en, xfer;
  logic [N-1:0]              grant, xfer_ln;
  logic [N-1:0][WIDTH-1:0]   lane_data;
  logic [N-1:0]              lane_last;
  beat_t                     sel_beat, out_q;

  // Reset gates acceptance so nothing is offered as taken while held in reset.
  assign load_en = Reset_n & (~out_valid | out_ready);

  // Arbiter: pick one candidate index, then expand it to a one-hot grant.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    if (state == LOCKED) begin
      // Only the locked channel is eligible; a dropped in_valid just stalls.
      for (int i = 0; i < N; i++) begin
        if (lock_ch == SELW'(i)) begin
          gnt_any = in_valid[i];
          gnt_idx = lock_ch;
        end
      end
    end else if (RR) begin
      // Search upward from rr_ptr, wrapping modulo N.
      for (int k = 0; k < N; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!gnt_any && in_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = SELW'(idx);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!gnt_any && in_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = SELW'(i);
        end
      end
    end
    for (int i = 0; i < N; i++)
      grant[i] = gnt_any && (gnt_idx == SELW'(i));
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    stream_mux_rr_lane #(.WIDTH(WIDTH)) u_lane (
      .grant    (grant[g]),
      .load_en  (load_en),
      .in_valid (in_valid[g]),
      .in_data  (in_data[g*WIDTH +: WIDTH]),
      .in_last  (in_last[g]),
      .in_ready (in_ready[g]),
      .xfer     (xfer_ln[g]),
      .sel_data (lane_data[g]),
      .sel_last (lane_last[g])
    );
  end

  assign xfer = |xfer_ln;

  // Grants are one-hot, so OR-reducing the masked lanes selects the winner.
  always_comb begin
    sel_beat = '0;
    for (int i = 0; i < N; i++) begin
      sel_beat.data = sel_beat.data | lane_data[i];
      sel_beat.last = sel_beat.last | lane_last[i];
    end
  end

  // Output register: load on transfer, otherwise drain when the sink takes it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_q     <= sel_beat;
      out_sel   <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_data = out_q.data;
  assign out_last = out_q.last;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && !sel_beat.last) state_nxt = LOCKED;
      LOCKED:  if (xfer &&  sel_beat.last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      lock_ch <= '0;
      rr_ptr  <= '0;
    end else begin
      state <= state_nxt;
      if (xfer && state == IDLE && !sel_beat.last)
        lock_ch <= gnt_idx;
      // Advance past the channel that just finished a packet.
      if (xfer && sel_beat.last)
        rr_ptr <= (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign busy = (state == LOCKED) | out_valid;

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;
  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic        Clk, Reset_n;
  logic [63:0] in_data;
  logic [3:0]  in_valid, in_last, in_ready, fp_in_ready;
  logic [15:0] out_data, fp_out_data;
  logic        out_valid, out_last, busy, out_ready;
  logic        fp_out_valid, fp_out_last, fp_busy;
  logic [1:0]  out_sel, fp_out_sel;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   mon_fp = 1'b0;

  stream_mux_rr #(.WIDTH(16), .N(4), .RR(1'b1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_sel(out_sel),
    .out_ready(out_ready), .busy(busy)
  );

  stream_mux_rr #(.WIDTH(16), .N(4), .RR(1'b0)) dut_fp (
    .Clk(Clk), .Reset_n(Reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(fp_in_ready), .out_data(fp_out_data),
    .out_valid(fp_out_valid), .out_last(fp_out_last), .out_sel(fp_out_sel),
    .out_ready(out_ready), .busy(fp_busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Scoreboard consumer: a beat leaves the DUT at the next edge when
  // out_valid & out_ready; compare it against the oldest expectation.
  logic        m_v, m_l;
  logic [1:0]  m_s;
  logic [15:0] m_d;
  exp_t        m_e;
  always @(negedge Clk) begin
    if (Reset_n) begin
      m_v = mon_fp ? fp_out_valid : out_valid;
      m_s = mon_fp ? fp_out_sel   : out_sel;
      m_d = mon_fp ? fp_out_data  : out_data;
      m_l = mon_fp ? fp_out_last  : out_last;
      if (m_v && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got sel=%0d data=%h last=%b, none expected", m_s, m_d, m_l);
        end else begin
          m_e = exp_q.pop_front();
          if ({m_s, m_d, m_l} !== {m_e.sel, m_e.data, m_e.last}) begin
            errors++;
            $display("FAIL beat: got sel=%0d data=%h last=%b, expected sel=%0d data=%h last=%b",
                     m_s, m_d, m_l, m_e.sel, m_e.data, m_e.last);
          end
        end
      end
    end
  end

  task automatic set_ch(input int ch, input logic [15:0] d);
    in_data[ch*16 +: 16] = d;
  endtask

  task automatic push(input int sel, input logic [15:0] d, input logic l);
    exp_t e;
    e.sel = 2'(sel); e.data = d; e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; in_data = '0; in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
    repeat (2) @(negedge Clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL rst_data: got %h want 0000", out_data); end
    checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL rst_sel: got %0d want 0", out_sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL rst_in_ready: got %b want 0000", in_ready); end
    @(posedge Clk); #1;
    in_valid = '0; Reset_n = 1'b1;
  endtask

  task automatic test_rr_fairness;
    @(posedge Clk); #1;
    in_last = 4'hF;
    for (int i = 0; i < 4; i++) set_ch(i, 16'(i * 16));
    in_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      int g, b;
      g = c % 4; b = c / 4;
      push(g, 16'(g * 16 + b), 1'b1);
      @(negedge Clk);
      checks++;
      if (in_ready !== 4'(1 << g)) begin
        errors++; $display("FAIL rr_ready cycle %0d: got %b want %b", c, in_ready, 4'(1 << g));
      end
      @(posedge Clk); #1;
      set_ch(g, 16'(g * 16 + b + 1));
    end
    in_valid = '0;
    repeat (2) @(negedge Clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_packet_lock;
    @(posedge Clk); #1;
    in_last = 4'b0000; set_ch(2, 16'h0020); in_valid = 4'b0100; push(2, 16'h0020, 1'b0);
    @(negedge Clk);
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL lock_b0_ready: got %b want 0100", in_ready); end
    @(posedge Clk); #1;
    set_ch(0, 16'hA000); set_ch(2, 16'h0021); in_last = 4'b0001; in_valid = 4'b0101;
    push(2, 16'h0021, 1'b0);
    @(negedge Clk);
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL lock_b1_ready: got %b want 0100", in_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lock_busy: got %b want 1", busy); end
    @(posedge Clk); #1;
    set_ch(2, 16'h0022); in_last = 4'b0101; push(2, 16'h0022, 1'b1);
    @(negedge Clk);
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL lock_b2_ready: got %b want 0100", in_ready); end
    @(posedge Clk); #1;
    in_valid = 4'b0001; push(0, 16'hA000, 1'b1);
    @(negedge Clk);
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL lock_wrap_ready: got %b want 0001", in_ready); end
    @(posedge Clk); #1;
    in_valid = '0;
    repeat (2) @(negedge Clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL lock_drain: got %0d pending want 0", exp_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_backpressure;
    @(posedge Clk); #1;
    out_ready = 1'b1; set_ch(1, 16'hBEEF); in_last = 4'b0010; in_valid = 4'b0010;
    push(1, 16'hBEEF, 1'b1);
    @(posedge Clk); #1;
    out_ready = 1'b0; set_ch(0, 16'h1234); in_last = 4'b0001; in_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'hBEEF || in_ready !== 4'h0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got valid=%b data=%h ready=%b want 1 BEEF 0000",
                 k, out_valid, out_data, in_ready);
      end
      @(posedge Clk); #1;
    end
    out_ready = 1'b1; push(0, 16'h1234, 1'b1);
    @(negedge Clk);
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL bp_resume_ready: got %b want 0001", in_ready); end
    @(posedge Clk); #1;
    in_valid = '0;
    repeat (2) @(negedge Clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_lock_stall;
    @(posedge Clk); #1;
    set_ch(1, 16'h0100); in_last = 4'b0000; in_valid = 4'b0010; push(1, 16'h0100, 1'b0);
    @(negedge Clk);
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL stall_b0_ready: got %b want 0010", in_ready); end
    @(posedge Clk); #1;
    set_ch(0, 16'h0ABC); in_last = 4'b0001; in_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      checks++;
      if (in_ready !== 4'h0 || busy !== 1'b1) begin
        errors++; $display("FAIL stall_hold cycle %0d: got ready=%b busy=%b want 0000 1", k, in_ready, busy);
      end
      @(posedge Clk); #1;
    end
    set_ch(1, 16'h0101); in_last = 4'b0011; in_valid = 4'b0011; push(1, 16'h0101, 1'b1);
    @(negedge Clk);
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL stall_resume_ready: got %b want 0010", in_ready); end
    @(posedge Clk); #1;
    in_valid = 4'b0001; push(0, 16'h0ABC, 1'b1);
    @(negedge Clk);
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL stall_after_ready: got %b want 0001", in_ready); end
    @(posedge Clk); #1;
    in_valid = '0;
    repeat (2) @(negedge Clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_packet;
    @(posedge Clk); #1;
    out_ready = 1'b0; set_ch(2, 16'h0777); in_last = 4'b0000; in_valid = 4'b0100;
    @(posedge Clk); #1;
    in_valid = '0;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: got busy=%b valid=%b want 1 1", busy, out_valid);
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_clear: got valid=%b data=%h busy=%b want 0 0000 0", out_valid, out_data, busy);
    end
    exp_q.delete();
    @(posedge Clk); #1;
    Reset_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_ch(i, 16'(16'h0F00 + i));
    in_last = 4'hF; in_valid = 4'hF; push(0, 16'h0F00, 1'b1);
    @(negedge Clk);
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL midrst_fresh_ready: got %b want 0001", in_ready); end
    @(posedge Clk); #1;
    in_valid = '0;
    repeat (2) @(negedge Clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_fixed_priority;
    @(posedge Clk); #1;
    mon_fp = 1'b1;
    set_ch(1, 16'h1111); set_ch(3, 16'h3333); in_last = 4'hF; in_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      push(1, 16'h1111, 1'b1);
      @(negedge Clk);
      checks++; if (fp_in_ready !== 4'b0010) begin errors++; $display("FAIL fp_ready cycle %0d: got %b want 0010", c, fp_in_ready); end
      @(posedge Clk); #1;
    end
    in_valid = 4'b1000; push(3, 16'h3333, 1'b1);
    @(negedge Clk);
    checks++; if (fp_in_ready !== 4'b1000) begin errors++; $display("FAIL fp_low_ready: got %b want 1000", fp_in_ready); end
    @(posedge Clk); #1;
    in_valid = '0;
    repeat (2) @(negedge Clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fp_drain: got %0d pending want 0", exp_q.size()); end
    mon_fp = 1'b0;
  endtask

  initial begin
    test_reset;
    test_rr_fairness;
    test_packet_lock;
    test_backpressure;
    test_lock_stall;
    test_reset_mid_packet;
    test_fixed_priority;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N:1 stream multiplexer with per-channel valid/ready handshakes and a registered output stage. It replaces hard-wired select-driven muxes wherever several 16-bit sources share one sink, such as the bus feeding MDR/IR. It arbitrates internally, either round-robin or fixed priority. A multi-beat packet marked by `last` is never interleaved with beats from another channel.

## Interface
- WIDTH, 16, data width per channel
- N, 4, number of input channels (N ≥ 1)
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins)
- SELW, derived: max(1, $clog2(N)), width of `out_sel`

- Clk  input  1  single clock, all state updates on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  channel i offers a beat
- in_last  input  N  beat on channel i is the final beat of its packet
- in_ready  output  N  beat on channel i accepted this cycle (at most one bit set)
- out_data  output  WIDTH  registered output data
- out_valid  output  1  output register holds a beat
- out_last  output  1  registered copy of the accepted beat's `last`
- out_sel  output  SELW  index of the channel that produced the current output beat
- out_ready  input  1  sink accepts the output beat
- busy  output  1  high when in LOCKED state or when `out_valid` = 1

## Operation
- Reset (Reset_n = 0, asynchronous): out_valid=0, out_data=0, out_last=0, out_sel=0, state=IDLE, rr_ptr=0, lock_ch=0. Reset mid-packet discards the packet. After release, all channels arbitrate from scratch.
- Load enable: load_en = !out_valid | out_ready. Only one output register exists, and no data is stored elsewhere.
- Grant is computed combinationally each cycle:
  - IDLE, RR=1: first i with in_valid[i]=1, searching from rr_ptr upward and wrapping modulo N.
  - IDLE, RR=0: lowest i with in_valid[i]=1.
  - LOCKED: channel lock_ch only, and only if in_valid[lock_ch]=1. All other channels are ignored.
  - No valid candidate: no grant.
- in_ready[i] = load_en & grant[i]. A transfer occurs on channel i when in_valid[i] & in_ready[i].
- On a transfer from channel g:
  - out_data ← in_data[g]
  - out_last ← in_last[g]
  - out_sel ← g
  - out_valid ← 1
- If out_valid=1 and out_ready=1 with no transfer, then out_valid ← 0. out_data, out_last and out_sel hold their values.
- If out_valid=1 and out_ready=0, every output holds stable and in_ready is all zeros.
- State machine:
  - IDLE → LOCKED (lock_ch ← g) on a transfer with in_last=0.
  - IDLE stays IDLE on a transfer with in_last=1, i.e. a single-beat packet.
  - LOCKED → IDLE on a transfer with in_last=1.
  - Otherwise, stay in the current state.
- RR pointer: on every transfer with in_last=1, rr_ptr ← (g+1) mod N. This includes the wrap from N-1 to 0. When RR=0, rr_ptr is unused.
- in_valid dropping mid-packet while LOCKED does not release the lock. The block waits on lock_ch indefinitely.
- N=1: out_sel is constant 0, and the block degenerates to a one-entry registered pipe.

## Timing
- Latency: a beat accepted at edge k appears on out_data/out_valid immediately after edge k, giving 1 cycle of latency.
- Throughput: 1 beat/cycle sustained when out_ready is held at 1, because load and drain happen in the same cycle.
- in_ready depends combinationally on in_valid, out_valid, out_ready and state. in_valid must not depend on in_ready.
- The lock decision and the grant in the cycle after the final beat already reflect the updated rr_ptr.

## Test plan
- Reset values: hold Reset_n=0, drive all in_valid=1. Expect out_valid=0, out_data=0, out_sel=0, busy=0, in_ready=0. Assert Reset_n=0 asynchronously mid-cycle during a LOCKED packet. Expect outputs to clear immediately and state to return to IDLE.
- Round-robin fairness (RR=1, N=4): hold all channels valid with single-beat packets, in_data[i]=16'h00i0+beat, out_ready=1. Expect out_sel sequence 0,1,2,3,0,1… with one beat per cycle after the first-cycle latency.
- Fixed priority (RR=0): hold channels 1 and 3 valid continuously. Expect out_sel=1 every cycle and channel 3 never granted. Drop in_valid[1]. Expect out_sel=3 on the next beat.
- Packet lock: channel 2 sends a 3-beat packet (last on beat 3) while channel 0 is continuously valid. Expect out_sel=2 for three consecutive beats and in_ready[0]=0 throughout. Then expect out_sel=0, with rr_ptr having advanced to 3 and wrapped.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 and data 16'hBEEF. Expect out_data to hold 16'hBEEF and in_ready to stay all zeros. Set out_ready=1. Expect the next beat to load in that same cycle.
- Stall inside a packet: in LOCKED state on channel 1, drop in_valid[1] for 3 cycles while channel 0 is valid. Expect no grants and busy=1. Resume channel 1. Expect the packet to continue on out_sel=1.
